// File: rtl/i8224_clkgen_pkg.sv
// Shared constants for the 8224-style clock sequencer.
//   CNT_W         : phase counter width (supports DIVIDE up to 16)
//   DEF_*         : default timing (9-clock CPU period, PHI1 2 clk,
//                   PHI2 rising at count 3 for 5 clk)
//   cnt_t         : phase counter type
//   cfg_legal()   : elaboration-time check of a timing configuration
package i8224_clkgen_pkg;

  localparam int unsigned CNT_W          = 4;
  localparam int unsigned DEF_DIVIDE     = 9;
  localparam int unsigned DEF_PHI1_LEN   = 2;
  localparam int unsigned DEF_PHI2_START = 3;
  localparam int unsigned DEF_PHI2_LEN   = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  // PHI1 must not overlap PHI2 (at least one idle clock between them) and
  // PHI2 must fall before the counter wraps.
  function automatic bit cfg_legal(int unsigned divide, int unsigned phi1_len,
                                   int unsigned phi2_start, int unsigned phi2_len);
    return (phi1_len >= 1) &&
           (phi2_start >= phi1_len + 1) &&
           (phi2_len >= 1) &&
           (phi2_start + phi2_len <= divide - 1) &&
           (divide <= 16);
  endfunction

endpackage

// File: rtl/i8224_clkgen_if.sv
// Bus between the clock sequencer and the CPU core / system controller.
//   master : the clock sequencer (takes sync/resin_n/rdyin, drives phases,
//            enables, status strobe, CPU reset and READY)
//   slave  : the consumer side
interface i8224_clkgen_if;

  logic sync;
  logic resin_n;
  logic rdyin;
  logic phi1;
  logic phi2;
  logic phi1_en;
  logic phi2_en;
  logic phi2_fall_en;
  logic ststb_n;
  logic reset_out;
  logic ready_out;

  modport master (
    input  sync, resin_n, rdyin,
    output phi1, phi2, phi1_en, phi2_en, phi2_fall_en,
           ststb_n, reset_out, ready_out
  );

  modport slave (
    output sync, resin_n, rdyin,
    input  phi1, phi2, phi1_en, phi2_en, phi2_fall_en,
           ststb_n, reset_out, ready_out
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level input.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears both flops to 0
//   d       : asynchronous input
//   q       : synchronised output (2 clk latency)
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i8224_clkgen.sv
// 8080 cycle sequencer: divides clk into the PHI1/PHI2 pattern, emits
// single-clock phase enables, the status strobe for the system controller
// and the PHI2-fall-aligned CPU reset and READY.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : master side of i8224_clkgen_if
//             in : sync, resin_n (async), rdyin (async)
//             out: phi1, phi2, phi1_en, phi2_en, phi2_fall_en,
//                  ststb_n, reset_out, ready_out (all registered)
module i8224_clkgen
  import i8224_clkgen_pkg::*;
#(
  parameter int unsigned DIVIDE     = DEF_DIVIDE,
  parameter int unsigned PHI1_LEN   = DEF_PHI1_LEN,
  parameter int unsigned PHI2_START = DEF_PHI2_START,
  parameter int unsigned PHI2_LEN   = DEF_PHI2_LEN
) (
  input  logic            clk,
  input  logic            reset_n,
  i8224_clkgen_if.master  bus
);

  if (!cfg_legal(DIVIDE, PHI1_LEN, PHI2_START, PHI2_LEN)) begin : g_cfg_illegal
    $error("i8224_clkgen: illegal phase timing configuration");
  end

  localparam cnt_t C_LAST    = cnt_t'(DIVIDE - 1);
  localparam cnt_t C_P1_END  = cnt_t'(PHI1_LEN);
  localparam cnt_t C_P2_RISE = cnt_t'(PHI2_START);
  localparam cnt_t C_P2_FALL = cnt_t'(PHI2_START + PHI2_LEN);

  cnt_t cnt;
  cnt_t cnt_nxt;
  logic sync_q;
  logic resin_s;
  logic rdyin_s;

  logic phi1_q, phi2_q, phi1_en_q, phi2_en_q, phi2_fall_en_q;
  logic ststb_n_q, reset_out_q, ready_out_q;

  sync2 u_sync_resin (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.resin_n),
    .q       (resin_s)
  );

  sync2 u_sync_rdy (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.rdyin),
    .q       (rdyin_s)
  );

  // Reset parks the counter at its last value so the first edge after
  // release wraps it to 0 and starts a fresh PHI1.
  always_comb begin
    cnt_nxt = (cnt == C_LAST) ? '0 : cnt + cnt_t'(1);
  end

  // Outputs decode cnt_nxt so every output reflects the count loaded on the
  // same edge without a combinational path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= C_LAST;
      sync_q         <= 1'b0;
      phi1_q         <= 1'b0;
      phi2_q         <= 1'b0;
      phi1_en_q      <= 1'b0;
      phi2_en_q      <= 1'b0;
      phi2_fall_en_q <= 1'b0;
      ststb_n_q      <= 1'b1;
      reset_out_q    <= 1'b1;
      ready_out_q    <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      phi1_q         <= (cnt_nxt < C_P1_END);
      phi2_q         <= (cnt_nxt >= C_P2_RISE) && (cnt_nxt < C_P2_FALL);
      phi1_en_q      <= (cnt_nxt == '0);
      phi2_en_q      <= (cnt_nxt == C_P2_RISE);
      phi2_fall_en_q <= (cnt_nxt == C_P2_FALL);
      // sync_q only changes at PHI2 fall, which is never inside the PHI1
      // window, so its registered value is the one in force for the strobe.
      ststb_n_q      <= !(sync_q && (cnt_nxt < C_P1_END));
      if (cnt_nxt == C_P2_FALL) begin
        sync_q      <= bus.sync;
        reset_out_q <= ~resin_s;
        ready_out_q <= rdyin_s;
      end
    end
  end

  assign bus.phi1         = phi1_q;
  assign bus.phi2         = phi2_q;
  assign bus.phi1_en      = phi1_en_q;
  assign bus.phi2_en      = phi2_en_q;
  assign bus.phi2_fall_en = phi2_fall_en_q;
  assign bus.ststb_n      = ststb_n_q;
  assign bus.reset_out    = reset_out_q;
  assign bus.ready_out    = ready_out_q;

endmodule
